// File: rtl/stopwatch_pkg.sv
//==============================================================================
// Module   : stopwatch_pkg
// Brief    : Mode encodings and default timing constants for stopwatch_ctrl.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

package stopwatch_pkg;

    localparam logic [1:0] ST_IDLE  = 2'b00;
    localparam logic [1:0] ST_RUN   = 2'b01;
    localparam logic [1:0] ST_LAP   = 2'b10;
    localparam logic [1:0] ST_PAUSE = 2'b11;

    localparam int DEF_DB_CYCLES   = 10000;
    localparam int DEF_LONG_CYCLES = 2000000;

endpackage

`default_nettype wire

// File: rtl/stopwatch_ctrl_debounce.sv
//==============================================================================
// Module   : btn_debounce
// Brief    : 2-flop synchroniser, stability counter, debounced level and a
//            one-cycle press pulse on the debounced rising edge.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module btn_debounce #(
    parameter int DB_CYCLES = 10000,
    parameter int CNT_W     = 16
) (
    input  logic mclk,
    input  logic reset,
    input  logic btn_raw,
    output logic level,
    output logic press
);

    localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(DB_CYCLES - 1);

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             level_q, level_d;
    logic             level_dly_q, level_dly_d;
    logic             press_q, press_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        sync1_d     = btn_raw;
        sync2_d     = sync1_q;
        level_d     = level_q;
        cnt_d       = '0;
        // Counter only advances on an uninterrupted run of differing samples
        if (sync2_q != level_q) begin
            if (cnt_q == C_CNT_LAST) begin
                level_d = ~level_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
        level_dly_d = level_q;
        press_d     = level_q & ~level_dly_q;
    end

    always_ff @(posedge mclk) begin
        if (reset) begin
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            level_q     <= 1'b0;
            level_dly_q <= 1'b0;
            press_q     <= 1'b0;
            cnt_q       <= '0;
        end else begin
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            level_q     <= level_d;
            level_dly_q <= level_dly_d;
            press_q     <= press_d;
            cnt_q       <= cnt_d;
        end
    end

    assign level = level_q;
    assign press = press_q;

endmodule

`default_nettype wire

// File: rtl/stopwatch_ctrl.sv
//==============================================================================
// Module   : stopwatch_ctrl
// Brief    : Debounces start/stop and lap/clear buttons and runs the stopwatch
//            mode FSM. Optional macro STOPWATCH_LONG_CLEAR_EN adds long-press
//            clear on the lap/clear button.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int DB_CYCLES   = DEF_DB_CYCLES,
    parameter int CNT_W       = 16,
    parameter int LONG_CYCLES = DEF_LONG_CYCLES
) (
    input  logic       mclk,
    input  logic       reset,
    input  logic       btn_ss,
    input  logic       btn_lc,
    output logic       run,
    output logic       clr,
    output logic       lap_hold,
    output logic [1:0] mode
);

    logic       ss_p, lc_p;
    logic       ss_level, lc_level;
    logic       unused_levels;
    logic [1:0] state_q, state_d;
    logic       run_q, run_d;
    logic       clr_q, clr_d;
    logic       lap_q, lap_d;

    btn_debounce #(.DB_CYCLES(DB_CYCLES), .CNT_W(CNT_W)) u_db_ss (
        .mclk    (mclk),
        .reset   (reset),
        .btn_raw (btn_ss),
        .level   (ss_level),
        .press   (ss_p)
    );

    btn_debounce #(.DB_CYCLES(DB_CYCLES), .CNT_W(CNT_W)) u_db_lc (
        .mclk    (mclk),
        .reset   (reset),
        .btn_raw (btn_lc),
        .level   (lc_level),
        .press   (lc_p)
    );

    assign unused_levels = ss_level ^ lc_level;

`ifdef STOPWATCH_LONG_CLEAR_EN
    localparam int LONG_W = $clog2(LONG_CYCLES + 1);
    localparam logic [LONG_W-1:0] C_LONG_FIRE = LONG_W'(LONG_CYCLES - 1);
    localparam logic [LONG_W-1:0] C_LONG_SAT  = LONG_W'(LONG_CYCLES);

    logic [LONG_W-1:0] long_cnt_q, long_cnt_d;
    logic              long_fire;

    // Saturating at LONG_CYCLES keeps the fire compare false for the rest of the hold
    always_comb begin
        long_cnt_d = '0;
        long_fire  = 1'b0;
        if (lc_level) begin
            long_cnt_d = long_cnt_q;
            if (long_cnt_q != C_LONG_SAT) begin
                long_cnt_d = long_cnt_q + 1'b1;
            end
            long_fire = (long_cnt_q == C_LONG_FIRE);
        end
    end

    always_ff @(posedge mclk) begin
        if (reset) begin
            long_cnt_q <= '0;
        end else begin
            long_cnt_q <= long_cnt_d;
        end
    end
`else
    localparam int LONG_CYCLES_UNUSED = LONG_CYCLES;
`endif

    always_comb begin
        state_d = state_q;
        clr_d   = 1'b0;
        if (ss_p) begin
            case (state_q)
                ST_IDLE:  state_d = ST_RUN;
                ST_RUN:   state_d = ST_PAUSE;
                ST_LAP:   state_d = ST_PAUSE;
                default:  state_d = ST_RUN;
            endcase
        end else if (lc_p) begin
            case (state_q)
                ST_IDLE:  clr_d   = 1'b1;
                ST_RUN:   state_d = ST_LAP;
                ST_LAP:   state_d = ST_RUN;
                default: begin
                    state_d = ST_IDLE;
                    clr_d   = 1'b1;
                end
            endcase
        end
`ifdef STOPWATCH_LONG_CLEAR_EN
        if (long_fire) begin
            state_d = ST_IDLE;
            clr_d   = 1'b1;
        end
`endif
        run_d = (state_d == ST_RUN) || (state_d == ST_LAP);
        lap_d = (state_d == ST_LAP);
    end

    always_ff @(posedge mclk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            run_q   <= 1'b0;
            clr_q   <= 1'b0;
            lap_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            run_q   <= run_d;
            clr_q   <= clr_d;
            lap_q   <= lap_d;
        end
    end

    assign mode     = state_q;
    assign run      = run_q;
    assign clr      = clr_q;
    assign lap_hold = lap_q;

endmodule

`default_nettype wire

// File: tb/tb_stopwatch_ctrl.sv
//==============================================================================
// Module   : tb_stopwatch_ctrl
// Brief    : Self-checking bench for stopwatch_ctrl (DB_CYCLES=4, LONG_CYCLES=50).
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_stopwatch_ctrl;

    localparam int DB   = 4;
    localparam int LONG = 50;

    logic       mclk   = 1'b0;
    logic       reset  = 1'b1;
    logic       btn_ss = 1'b0;
    logic       btn_lc = 1'b0;
    logic       run, clr, lap_hold;
    logic [1:0] mode;

    int vectors     = 0;
    int miscompares = 0;
    bit chk_en      = 1'b0;

    always #5 mclk = ~mclk;

    stopwatch_ctrl #(.DB_CYCLES(DB), .CNT_W(16), .LONG_CYCLES(LONG)) dut (
        .mclk     (mclk),
        .reset    (reset),
        .btn_ss   (btn_ss),
        .btn_lc   (btn_lc),
        .run      (run),
        .clr      (clr),
        .lap_hold (lap_hold),
        .mode     (mode)
    );

    // Reference model: index 0 = start/stop, 1 = lap/clear; mode 0..3 = IDLE/RUN/LAP/PAUSE
    bit m_s1[2], m_s2[2], m_lvl[2], m_lvl_prev[2], m_press[2];
    int m_stable[2];
    int m_mode = 0;
    bit m_clr  = 1'b0;
    int m_long = 0;

    always @(posedge mclk) begin : model
        bit raw[2];
        int nxt;
        bit c;
        raw[0] = btn_ss;
        raw[1] = btn_lc;
        if (reset) begin
            for (int b = 0; b < 2; b++) begin
                m_s1[b] = 0; m_s2[b] = 0; m_lvl[b] = 0; m_lvl_prev[b] = 0;
                m_press[b] = 0; m_stable[b] = 0;
            end
            m_mode = 0; m_clr = 0; m_long = 0;
        end else begin
            nxt = m_mode;
            c   = 0;
            if (m_press[0]) begin
                nxt = (m_mode == 1 || m_mode == 2) ? 3 : 1;
            end else if (m_press[1]) begin
                case (m_mode)
                    0: c = 1;
                    1: nxt = 2;
                    2: nxt = 1;
                    default: begin nxt = 0; c = 1; end
                endcase
            end
`ifdef STOPWATCH_LONG_CLEAR_EN
            m_long = m_lvl[1] ? m_long + 1 : 0;
            if (m_long == LONG) begin nxt = 0; c = 1; end
`endif
            m_mode = nxt;
            m_clr  = c;
            for (int b = 0; b < 2; b++) begin
                m_press[b]    = m_lvl[b] && !m_lvl_prev[b];
                m_lvl_prev[b] = m_lvl[b];
                m_stable[b]   = (m_s2[b] != m_lvl[b]) ? m_stable[b] + 1 : 0;
                if (m_stable[b] == DB) begin
                    m_lvl[b]    = !m_lvl[b];
                    m_stable[b] = 0;
                end
                m_s2[b] = m_s1[b];
                m_s1[b] = raw[b];
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge mclk) begin
        if (chk_en) begin
            chk("model.mode", 32'(mode), 32'(m_mode));
            chk("model.run", 32'(run), 32'(m_mode == 1 || m_mode == 2));
            chk("model.clr", 32'(clr), 32'(m_clr));
            chk("model.lap_hold", 32'(lap_hold), 32'(m_mode == 2));
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge mclk);
    endtask

    initial begin
        tick(3);
        chk("reset.mode", 32'(mode), 0);
        chk("reset.run", 32'(run), 0);
        chk("reset.clr", 32'(clr), 0);
        chk("reset.lap_hold", 32'(lap_hold), 0);
        chk_en = 1'b1;
        reset  = 1'b0;
        tick(2);

        // First press: pulse after DB+3 edges, state visible one edge later
        btn_ss = 1; tick(7);
        chk("ss_latency.before", 32'(mode), 0);
        tick(1);
        chk("ss_latency.mode", 32'(mode), 1);
        chk("ss_latency.run", 32'(run), 1);
        chk("ss_latency.clr", 32'(clr), 0);
        btn_ss = 0; tick(10);
        chk("release.no_event", 32'(mode), 1);

        btn_lc = 1; tick(3); btn_lc = 0; tick(10);
        chk("glitch.mode", 32'(mode), 1);
        btn_lc = 1; tick(10);
        chk("lap.mode", 32'(mode), 2);
        chk("lap.lap_hold", 32'(lap_hold), 1);
        chk("lap.run", 32'(run), 1);
        btn_lc = 0; tick(10);
        btn_lc = 1; tick(8);
        chk("lap_exit.mode", 32'(mode), 1);
        chk("lap_exit.lap_hold", 32'(lap_hold), 0);
        btn_lc = 0; tick(10);

        btn_ss = 1; tick(8);
        chk("pause.mode", 32'(mode), 3);
        chk("pause.run", 32'(run), 0);
        btn_ss = 0; tick(10);
        btn_lc = 1; tick(7);
        chk("clear.before", 32'(clr), 0);
        tick(1);
        chk("clear.mode", 32'(mode), 0);
        chk("clear.pulse", 32'(clr), 1);
        tick(1);
        chk("clear.one_cycle", 32'(clr), 0);
        btn_lc = 0; tick(10);
        btn_lc = 1; tick(8);
        chk("idle_clear.pulse", 32'(clr), 1);
        chk("idle_clear.mode", 32'(mode), 0);
        tick(1);
        chk("idle_clear.one_cycle", 32'(clr), 0);
        btn_lc = 0; tick(10);

        btn_ss = 1; tick(8); btn_ss = 0; tick(10);
        btn_ss = 1; btn_lc = 1; tick(8);
        chk("both.mode", 32'(mode), 3);
        chk("both.clr", 32'(clr), 0);
        btn_ss = 0; btn_lc = 0; tick(10);

        btn_ss = 1; tick(8); btn_ss = 0; tick(10);
        btn_lc = 1; tick(8); btn_lc = 0; tick(10);
        chk("pre_reset.mode", 32'(mode), 2);
        btn_ss = 1; tick(1); btn_ss = 0; tick(1); btn_ss = 1; tick(2);
        reset = 1; tick(1);
        chk("midreset.mode", 32'(mode), 0);
        chk("midreset.run", 32'(run), 0);
        chk("midreset.lap_hold", 32'(lap_hold), 0);
        chk("midreset.clr", 32'(clr), 0);
        tick(2);
        reset = 0; tick(7);
        chk("post_reset.before", 32'(mode), 0);
        tick(1);
        chk("post_reset.press", 32'(mode), 1);
        btn_ss = 0; tick(10);

`ifdef STOPWATCH_LONG_CLEAR_EN
        btn_lc = 1; tick(8);
        chk("long.press_lap", 32'(mode), 2);
        tick(47);
        chk("long.before", 32'(clr), 0);
        tick(1);
        chk("long.mode", 32'(mode), 0);
        chk("long.clr", 32'(clr), 1);
        tick(1);
        chk("long.one_cycle", 32'(clr), 0);
        tick(3);
        chk("long.no_repeat", 32'(clr), 0);
        btn_lc = 0; tick(10);
`endif

        for (int i = 0; i < 500; i++) begin
            if ($urandom_range(0, 39) == 0) begin
                reset = 1; tick($urandom_range(1, 2)); reset = 0;
            end
            btn_ss = 1'($urandom_range(0, 1));
            btn_lc = 1'($urandom_range(0, 1));
            tick($urandom_range(1, ($urandom_range(0, 9) == 0) ? 70 : 12));
        end
        btn_ss = 0; btn_lc = 0; tick(12);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
